switch_debouncer: RTL

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/switch_debouncer.sv | 107 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
package debounce_pkg;

  localparam int unsigned GLITCH_W = 8;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  // Saturating increment for the rejected-transition counter.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == '1) ? v : v + GLITCH_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: qualifies level changes over STABLE_CNT sample strobes.
// Define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer on sw_raw.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 20,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic                sw_raw,
  output logic                db_level,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic                sw_in;
  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_d;
  logic                db_d, busy_d;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (sw_raw),
    .q     (sw_in)
  );
`else
  assign sw_in = sw_raw;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ZERO;
      cnt_q      <= '0;
      glitch_cnt <= '0;
      db_level   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      glitch_cnt <= glitch_d;
      db_level   <= db_d;
      busy       <= busy_d;
    end
  end

  // Next state; a revert always wins over a coincident sample strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_cnt;
    case (state_q)
      ZERO: begin
        if (sw_in) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sw_in) begin
          state_d  = ZERO;
          glitch_d = sat_inc(glitch_cnt);
        end else if (sample_en) begin
          if (cnt_q == LAST) begin
            state_d = ONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ONE: begin
        if (!sw_in) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sw_in) begin
          state_d  = ONE;
          glitch_d = sat_inc(glitch_cnt);
        end else if (sample_en) begin
          if (cnt_q == LAST) begin
            state_d = ZERO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
    db_d   = (state_d == ONE)   || (state_d == WAIT0);
    busy_d = (state_d == WAIT1) || (state_d == WAIT0);
  end

endmodule
